// File: rtl/parity_serial_link_if.sv
// Word-side handshake plus the one-bit serial channel of the parity serial link.
// slave is the link's own view; master is the word source / serial driver side.
interface parity_serial_link_if #(
    parameter int DATA_W = 8
);
    logic              odd_mode;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              ser_out;
    logic              ser_valid;
    logic              ser_par;
    logic              ser_in;
    logic              ser_in_valid;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_err;

    modport slave (
        input  odd_mode, in_valid, in_data, ser_in, ser_in_valid,
        output in_ready, ser_out, ser_valid, ser_par, rx_data, rx_valid, rx_err
    );

    modport master (
        output odd_mode, in_valid, in_data, ser_in, ser_in_valid,
        input  in_ready, ser_out, ser_valid, ser_par, rx_data, rx_valid, rx_err
    );
endinterface

// File: rtl/parity_serial_link.sv
// Serial parity link: TX serialises words LSB-first plus one parity bit,
// RX deserialises the same frame and flags parity mismatches.
module parity_serial_link #(
    parameter int DATA_W      = 8,
    parameter bit ODD_DEFAULT = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    parity_serial_link_if.slave  bus
);
    localparam int               CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DATA_W);

    typedef enum logic [1:0] {TX_IDLE, TX_DATA, TX_PAR} tx_state_e;

    tx_state_e         tx_state_q, tx_state_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
    logic              tx_odd_q, tx_odd_d;
    logic              tx_xor_q, tx_xor_d;
    logic              ser_out_q, ser_out_d;
    logic              ser_valid_q, ser_valid_d;
    logic              ser_par_q, ser_par_d;
    logic              tx_accept;

    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
    logic              rx_odd_q, rx_odd_d;
    logic              rx_err_q, rx_err_d;
    logic              rx_valid_q, rx_valid_d;

    // PAR accepts too, which is what gives back-to-back frames with no idle gap
    assign bus.in_ready = ~rst & (tx_state_q != TX_DATA);
    assign tx_accept    = bus.in_valid & bus.in_ready;

    assign bus.ser_out   = ser_out_q;
    assign bus.ser_valid = ser_valid_q;
    assign bus.ser_par   = ser_par_q;
    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.rx_err    = rx_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q  <= TX_IDLE;
            tx_shift_q  <= '0;
            tx_cnt_q    <= '0;
            tx_odd_q    <= ODD_DEFAULT;
            tx_xor_q    <= 1'b0;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            ser_par_q   <= 1'b0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_cnt_q    <= '0;
            rx_odd_q    <= ODD_DEFAULT;
            rx_err_q    <= 1'b0;
            rx_valid_q  <= 1'b0;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_shift_q  <= tx_shift_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_odd_q    <= tx_odd_d;
            tx_xor_q    <= tx_xor_d;
            ser_out_q   <= ser_out_d;
            ser_valid_q <= ser_valid_d;
            ser_par_q   <= ser_par_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_odd_q    <= rx_odd_d;
            rx_err_q    <= rx_err_d;
            rx_valid_q  <= rx_valid_d;
        end
    end

    // Serial outputs are computed one cycle ahead; tx_cnt_q counts bits already on the wire
    always_comb begin
        tx_state_d  = tx_state_q;
        tx_shift_d  = tx_shift_q;
        tx_cnt_d    = tx_cnt_q;
        tx_odd_d    = tx_odd_q;
        tx_xor_d    = tx_xor_q;
        ser_out_d   = 1'b0;
        ser_valid_d = 1'b0;
        ser_par_d   = 1'b0;

        case (tx_state_q)
            TX_DATA: begin
                ser_valid_d = 1'b1;
                if (tx_cnt_q == LAST) begin
                    tx_state_d = TX_PAR;
                    ser_out_d  = tx_xor_q ^ tx_odd_q;
                    ser_par_d  = 1'b1;
                end else begin
                    ser_out_d  = tx_shift_q[0];
                    tx_shift_d = {1'b0, tx_shift_q[DATA_W-1:1]};
                    tx_cnt_d   = tx_cnt_q + 1'b1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase

        if (tx_accept) begin
            tx_state_d  = TX_DATA;
            tx_shift_d  = {1'b0, bus.in_data[DATA_W-1:1]};
            tx_cnt_d    = CNT_W'(1);
            tx_odd_d    = bus.odd_mode;
            tx_xor_d    = ^bus.in_data;
            ser_out_d   = bus.in_data[0];
            ser_valid_d = 1'b1;
            ser_par_d   = 1'b0;
        end
    end

    always_comb begin
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_cnt_d   = rx_cnt_q;
        rx_odd_d   = rx_odd_q;
        rx_err_d   = rx_err_q;
        rx_valid_d = 1'b0;

        if (bus.ser_in_valid) begin
            if (rx_cnt_q == '0) begin
                rx_odd_d = bus.odd_mode;
            end
            if (rx_cnt_q == LAST) begin
                rx_data_d  = rx_shift_q;
                rx_err_d   = bus.ser_in ^ (^rx_shift_q) ^ rx_odd_q;
                rx_valid_d = 1'b1;
                rx_cnt_d   = '0;
            end else begin
                rx_shift_d = {bus.ser_in, rx_shift_q[DATA_W-1:1]};
                rx_cnt_d   = rx_cnt_q + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_parity_serial_link.sv
// Directed bench for parity_serial_link: TX framing, back-to-back frames,
// buffered loopback with RX gaps, parity corruption and mid-frame reset.
module tb_parity_serial_link;
    localparam int DATA_W = 8;

    logic clk = 1'b0;
    logic rst;

    parity_serial_link_if #(.DATA_W(DATA_W)) link ();

    parity_serial_link #(
        .DATA_W     (DATA_W),
        .ODD_DEFAULT(1'b0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(link)
    );

    always #5 clk = ~clk;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;
    int serRun     = 0;
    int peakRun    = 0;
    logic rxPulse  = 1'b0;
    logic [DATA_W:0] sbQueue[$];
    logic            txBits[$];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One clock: land on the falling edge, capture TX bits and score any RX word
    task automatic step();
        logic [DATA_W:0] expv;
        @(negedge clk);
        if (link.ser_valid === 1'b1) begin
            txBits.push_back(link.ser_out);
            serRun++;
            if (serRun > peakRun) peakRun = serRun;
        end else begin
            serRun = 0;
        end
        rxPulse = link.rx_valid;
        if (link.rx_valid === 1'b1) begin
            if (sbQueue.size() == 0) begin
                checkOutput("rx_unexpected", 32'(link.rx_valid), 32'd0);
            end else begin
                expv = sbQueue.pop_front();
                checkOutput("rx_data", 32'(link.rx_data), 32'(expv[DATA_W-1:0]));
                checkOutput("rx_err", 32'(link.rx_err), 32'(expv[DATA_W]));
            end
        end
    endtask

    // Present a word and return in the cycle after the accepting edge
    task automatic applyStimulus(input logic [DATA_W-1:0] word, input logic odd);
        int waitCycles = 0;
        link.in_valid = 1'b1;
        link.in_data  = word;
        link.odd_mode = odd;
        while (link.in_ready !== 1'b1 && waitCycles < 50) begin
            step();
            waitCycles++;
        end
        checkOutput("in_ready_wait", 32'(link.in_ready), 32'd1);
        step();
    endtask

    task automatic expectFrame(input logic [DATA_W-1:0] word, input logic odd, input string tag);
        logic [2:0] expBits;
        for (int k = 0; k <= DATA_W; k++) begin
            if (k < DATA_W) expBits = {2'b10, word[k]};
            else            expBits = {2'b11, (^word) ^ odd};
            checkOutput(tag, 32'({link.ser_valid, link.ser_par, link.ser_out}), 32'(expBits));
            if (k == 3) checkOutput({tag, "_busy"}, 32'(link.in_ready), 32'd0);
            step();
        end
    endtask

    // Transmit one frame, then replay the captured bits into RX with gaps
    task automatic loopbackFrame(input logic [DATA_W-1:0] word, input logic odd, input bit flipPar, input int parGap);
        logic            b;
        int              gap;
        logic [DATA_W:0] expv;
        txBits.delete();
        applyStimulus(word, odd);
        link.in_valid = 1'b0;
        repeat (DATA_W + 1) step();
        checkOutput("tx_bits", 32'(txBits.size()), 32'(DATA_W + 1));
        expv = {flipPar, word};
        sbQueue.push_back(expv);
        for (int k = 0; k <= DATA_W; k++) begin
            b = txBits[k];
            if (k == DATA_W && flipPar) b = ~b;
            gap = (k == DATA_W) ? parGap : int'($urandom_range(0, 2));
            link.ser_in_valid = 1'b0;
            repeat (gap) step();
            link.ser_in       = b;
            link.ser_in_valid = 1'b1;
            step();
            if (k == 0) link.odd_mode = ~odd;
        end
        link.ser_in_valid = 1'b0;
        checkOutput("rx_latency", 32'(rxPulse), 32'd1);
        checkOutput("sb_drained", 32'(sbQueue.size()), 32'd0);
        step();
        checkOutput("rx_pulse_width", 32'(rxPulse), 32'd0);
        checkOutput("rx_hold", 32'({link.rx_err, link.rx_data}), 32'(expv));
    endtask

    initial begin
        logic [DATA_W-1:0] rxWord;
        rst               = 1'b1;
        link.odd_mode     = 1'b0;
        link.in_valid     = 1'b0;
        link.in_data      = '0;
        link.ser_in       = 1'b0;
        link.ser_in_valid = 1'b0;

        repeat (3) begin
            step();
            checkOutput("reset_in_ready", 32'(link.in_ready), 32'd0);
        end
        checkOutput("reset_outputs", 32'({link.ser_out, link.ser_valid, link.ser_par,
                    link.rx_valid, link.rx_err, link.rx_data}), 32'd0);
        rst = 1'b0;
        step();
        checkOutput("ready_after_reset", 32'(link.in_ready), 32'd1);

        applyStimulus(8'hA5, 1'b0);
        link.in_valid = 1'b0;
        expectFrame(8'hA5, 1'b0, "even_a5");
        checkOutput("idle_after_frame", 32'(link.ser_valid), 32'd0);

        // Source holds in_valid; the second word and its mode change wait for PAR
        peakRun = 0;
        applyStimulus(8'hA5, 1'b1);
        link.in_data  = 8'h07;
        link.odd_mode = 1'b0;
        expectFrame(8'hA5, 1'b1, "b2b_odd_a5");
        link.in_valid = 1'b0;
        expectFrame(8'h07, 1'b0, "b2b_even_07");
        checkOutput("b2b_run", 32'(peakRun), 32'd18);

        for (int f = 0; f < 6; f++) begin
            loopbackFrame(DATA_W'($urandom), 1'($urandom_range(0, 1)), 1'b0,
                          (f == 2) ? 12 : int'($urandom_range(0, 2)));
        end

        for (int f = 0; f < 3; f++) begin
            loopbackFrame(DATA_W'($urandom), 1'($urandom_range(0, 1)), (f == 1), 1);
        end

        // Reset lands while TX shows its fourth data bit and RX holds three bits
        rxWord = 8'h5A;
        txBits.delete();
        applyStimulus(8'h3C, 1'b0);
        link.in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            link.ser_in       = rxWord[k];
            link.ser_in_valid = 1'b1;
            step();
        end
        checkOutput("pre_reset_bit3", 32'({link.ser_valid, link.ser_out}), 32'({1'b1, 1'b1}));
        link.ser_in = rxWord[3];
        rst         = 1'b1;
        step();
        checkOutput("midframe_reset_outputs", 32'({link.in_ready, link.ser_out, link.ser_valid,
                    link.ser_par, link.rx_valid, link.rx_err, link.rx_data}), 32'd0);
        link.ser_in_valid = 1'b0;
        step();
        rst = 1'b0;
        step();
        checkOutput("ready_after_midframe_reset", 32'(link.in_ready), 32'd1);
        checkOutput("no_partial_rx", 32'(sbQueue.size()), 32'd0);
        loopbackFrame(8'h96, 1'b1, 1'b0, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d checks done", checkCount);
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/parity_serial_link.md
# parity_serial_link

Parametrised serial parity link: a TX half accepts DATA_W-bit words over a valid/ready handshake and shifts them out LSB-first followed by one even or odd parity bit. An RX half deserialises the same frame format, regenerates parity and flags mismatches. It is the clocked, width-generic next generation of the 4-bit combinational even-parity generator and sits between word-level logic and a one-bit serial channel, with TX and RX loop-backable for test.

## Interface
Parameters:
- DATA_W, default 8: word width; legal range 2..32.
- ODD_DEFAULT, default 0: parity mode loaded at reset (0 = even, 1 = odd).

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- odd_mode  in  1  parity mode, sampled per frame (see Operation).
- in_valid  in  1  TX word valid.
- in_data  in  DATA_W  TX word.
- in_ready  out  1  TX can accept a word this cycle.
- ser_out  out  1  serial TX bit.
- ser_valid  out  1  ser_out is meaningful this cycle.
- ser_par  out  1  ser_out is the parity bit.
- ser_in  in  1  serial RX bit.
- ser_in_valid  in  1  ser_in is meaningful this cycle.
- rx_data  out  DATA_W  last received word.
- rx_valid  out  1  one-cycle pulse: rx_data and rx_err are updated.
- rx_err  out  1  parity mismatch on the frame reported by rx_valid.

## Operation
- Parity function: even gives p = ^data, so data plus p has an even count of ones. Odd gives p = ~^data.
- TX FSM has three states:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch in_data into the shift register, latch odd_mode into tx_odd, compute p, go to DATA, and clear the bit counter.
  - DATA: drive ser_out = shift[0] with ser_valid=1 and ser_par=0. Shift right each cycle. After DATA_W bits, go to PAR.
  - PAR: drive ser_out = p with ser_valid=1 and ser_par=1. in_ready=1, so a word accepted this cycle goes straight to DATA; otherwise go to IDLE.
- RX counter advances only on cycles with ser_in_valid=1. Gaps of any length hold state.
  - The first valid bit of a frame samples odd_mode into rx_odd.
  - Bits 0..DATA_W-1 shift in LSB-first.
  - Bit DATA_W is the parity bit. On that cycle, register rx_data, set rx_err = (received p != regenerated p), pulse rx_valid, and reset the counter.
- rx_data and rx_err hold their values between rx_valid pulses.
- A change of odd_mode in the middle of a frame has no effect on that frame.

## Timing
- Reset:
  - State is IDLE, counters 0, shift register 0, tx_odd and rx_odd = ODD_DEFAULT.
  - ser_out, ser_valid, ser_par, rx_data, rx_valid and rx_err are all 0.
  - in_ready is forced to 0 while rst=1 and becomes 1 in the first cycle after rst deasserts.
- TX latency: a word accepted at edge N puts bit 0 on ser_out in cycle N+1. The parity bit appears in cycle N+1+DATA_W.
- Frame length is DATA_W+1 cycles. Back-to-back frames have zero idle cycles.
- in_data and odd_mode are ignored unless in_valid&&in_ready.
- Outputs ser_* are registered; in_ready is decoded from the state.
- RX latency: rx_valid rises in the cycle after the edge that samples the parity bit.
- Boundary conditions:
  - in_valid held high continuously: one word is accepted every DATA_W+1 cycles. ser_valid stays 1 with no gap.
  - in_valid arrives during DATA: it is not accepted; the source holds the word until in_ready=1.
  - rst asserted mid-frame, TX or RX: the frame is aborted, outputs return to reset values on the next edge, and no rx_valid is produced for the partial frame.
  - RX gap just before the parity bit: rx_valid waits for the parity bit however long the gap is.

## Test plan
- Reset: hold rst for 3 cycles -> all outputs 0 and in_ready=0 during reset; in_ready=1 on the first cycle after release.
- DATA_W=8, even mode, send 0xA5 -> ser_out reads 1,0,1,0,0,1,0,1 then parity 0 (ser_par=1) in cycles N+1..N+9.
- Odd mode, send 0xA5, then even mode, send 0x07 -> parity bits 1 and 1. With in_valid held high the frames are back-to-back, 18 consecutive ser_valid cycles.
- Loopback ser_out to ser_in, random words, randomly inserted RX gaps, random odd_mode per frame -> rx_data equals the transmitted word and rx_err=0 every frame.
- Loopback with the parity bit of the second frame inverted in flight -> that frame gives rx_err=1 with rx_data still correct; neighbouring frames give rx_err=0.
- Assert rst at the fourth data bit of a frame -> no rx_valid for that frame; the next full frame is received correctly.
